ps2_key_sequencer: RTL and testbench
====================================

// Module: ps2_key_sequencer
// PURPOSE
//  Controls the PS2 keycode path between the PS2 byte receiver and the Nios II custom-instruction port.
//  Pops raw bytes from the receiver and folds E0/F0 prefixes into single make/break key events.
//  Queues the events and returns one per custom-instruction call with a start/done handshake.
//  Lets the CPU and the synth voice logic read whole key events instead of polling raw bytes.
// PARAMETERS
//  EVT_DEPTH    8      event queue depth; power of 2, >= 2
//  TIMEOUT_CYC  50000  clk cycles to wait for the byte after a prefix before the prefix is dropped
// PORTS
//  clk        in   1    system clock; all logic on posedge
//  reset_n    in   1    asynchronous, active-low reset
//  rx_valid   in   1    receiver holds an unread byte on rx_data
//  rx_data    in   8    receiver byte
//  rx_read    out  1    one-cycle pop strobe to receiver
//  clk_en     in   1    custom-instruction clock enable
//  start      in   1    custom-instruction start
//  done       out  1    custom-instruction done, 1-cycle pulse
//  result     out  32   {valid, ovf, 20'b0, ext, brk, code[7:0]}; valid=bit31, ovf=bit30, ext=bit9, brk=bit8
//  evt_count  out  $clog2(EVT_DEPTH)+1  events currently queued
//  overflow   out  1    sticky: an event was dropped because the queue was full
// BEHAVIOUR
//  Reset (reset_n=0, async): rx_read=0, done=0, result=0, evt_count=0, overflow=0.
//    Reset also empties the queue, clears ext/brk flags and the timer, and puts the assembler in A_IDLE.
//  Assembler FSM (A_IDLE, A_EVAL, A_WAIT):
//   A_IDLE: if rx_valid, latch rx_data into byte_r, register rx_read=1 for exactly one cycle, go to A_EVAL.
//   A_EVAL (1 cycle; rx_read high here):
//     E0 -> ext=1, clear timer, go to A_WAIT.
//     F0 -> brk=1, clear timer, go to A_WAIT.
//     E1, 00 or FF -> discard, clear ext/brk, go to A_IDLE.
//     any other byte -> push {ext,brk,byte_r}, clear ext/brk, go to A_IDLE.
//   A_WAIT: if rx_valid, pop/latch as in A_IDLE and go to A_EVAL (E0 F0 chains accumulate).
//     Otherwise the timer increments; at TIMEOUT_CYC-1, clear ext/brk, go to A_IDLE, push no event.
//   rx_valid is never sampled in A_EVAL, so a byte is never popped twice.
//  Custom-instruction side:
//   start & clk_en at edge N: done=1 in cycle N+1 only, so latency is 1.
//     result loads at edge N: queue non-empty -> {1,overflow,..,head}, then pop head; empty -> 32'h0.
//     overflow is shown in bit30 of that result and cleared by the read; the register bit clears at the same edge.
//   start with clk_en=0: ignored; no pop, done stays 0, result holds.
//   result holds its value until the next accepted start.
//  Queue boundaries:
//   full push without pop: event dropped, overflow<=1, evt_count unchanged.
//   full with push and pop same cycle: both succeed, no overflow.
//   empty with push and pop same cycle: read returns 0, push lands, evt_count becomes 1; no bypass.
//   overflow set and read-clear same cycle: the set wins.
//  Pointers wrap modulo EVT_DEPTH.
//  Reset mid-prefix: the partial sequence is lost. The first full code after reset produces a clean event.
// STRUCTURE
//  ps2_defs.vh: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
//    It also holds the result bit positions (VALID=31, OVF=30, EXT=9, BRK=8) and the assembler state encodings.
//  Sub-module ps2_evt_fifo: synchronous FIFO, 10-bit words, depth EVT_DEPTH.
//    ports: push, pop, din, dout, full, empty, count. Same-cycle push+pop allowed when full.
//  Top level: assembler FSM, prefix timer, CI handshake and overflow flag.
// TESTING
//  1. bytes 1C; start+clk_en -> done one cycle later, result=32'h8000_001C, evt_count 1->0.
//  2. F0 1C -> 32'h8000_011C; E0 F0 75 -> 32'h8000_0375; E0 75 -> 32'h8000_0275.
//  3. E0, idle TIMEOUT_CYC cycles, then 1C -> single event 32'h8000_001C.
//  4. 9 codes (DEPTH 8), no reads -> evt_count=8, overflow=1.
//     1st read 32'hC000_00xx; reads 2-8 bit30=0; 9th read 32'h0.
//  5. start with clk_en=0 -> done=0, no pop; when full, push and pop same cycle -> overflow stays 0.
//  6. reset_n low during A_WAIT after E0 -> all outputs 0 at once; then 1C -> 32'h8000_001C.

Source files
------------

// File: rtl/ps2_key_sequencer_pkg.sv
// Shared PS2 byte codes, result bit positions, assembler state encodings
// and the key event word that travels through the event queue.
package ps2_key_sequencer_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  localparam int RES_VALID = 31;
  localparam int RES_OVF   = 30;
  localparam int RES_EXT   = 9;
  localparam int RES_BRK   = 8;

  localparam logic [1:0] A_IDLE = 2'd0;
  localparam logic [1:0] A_EVAL = 2'd1;
  localparam logic [1:0] A_WAIT = 2'd2;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_PAUSE) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  function automatic logic [31:0] pack_result(input key_evt_t e, input logic ovf);
    logic [31:0] r;
    r            = '0;
    r[RES_VALID] = 1'b1;
    r[RES_OVF]   = ovf;
    r[RES_EXT]   = e.ext;
    r[RES_BRK]   = e.brk;
    r[7:0]       = e.code;
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_evt_fifo.sv
// Synchronous FIFO for key events; a pop frees the slot a same-cycle push
// needs, so push+pop succeeds even when full.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Folds raw PS2 bytes (E0/F0 prefixes) into make/break key events, queues
// them, and hands one event per Nios II custom-instruction call.
module ps2_key_sequencer
  import ps2_key_sequencer_pkg::*;
#(
  parameter int EVT_DEPTH   = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_read,
  input  logic                          clk_en,
  input  logic                          start,
  output logic                          done,
  output logic [31:0]                   result,
  output logic [$clog2(EVT_DEPTH):0]    evt_count,
  output logic                          overflow
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_read_q, rx_read_d;
  logic          done_q;
  logic [31:0]   result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, accept, fifo_full, fifo_empty;
  key_evt_t      evt_in, evt_out;

  assign evt_in = '{ext: ext_q, brk: brk_q, code: byte_q};

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    timer_d   = timer_q;
    rx_read_d = 1'b0;
    push      = 1'b0;
    case (state_q)
      A_IDLE: begin
        if (rx_valid) begin
          byte_d    = rx_data;
          rx_read_d = 1'b1;
          state_d   = A_EVAL;
        end
      end
      A_EVAL: begin
        if (byte_q == PS2_EXT) begin
          ext_d   = 1'b1;
          timer_d = '0;
          state_d = A_WAIT;
        end else if (byte_q == PS2_BRK) begin
          brk_d   = 1'b1;
          timer_d = '0;
          state_d = A_WAIT;
        end else begin
          push    = ~is_discard(byte_q);
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          state_d = A_IDLE;
        end
      end
      A_WAIT: begin
        if (rx_valid) begin
          byte_d    = rx_data;
          rx_read_d = 1'b1;
          state_d   = A_EVAL;
        end else if (timer_q == TMO_LAST) begin
          // A prefix with no follow-up byte is stale; drop it silently.
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          state_d = A_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  assign accept   = start & clk_en;
  assign pop      = accept & ~fifo_empty;
  assign result_d = accept ? (fifo_empty ? 32'h0 : pack_result(evt_out, ovf_q)) : result_q;
  // A dropped push outranks the read-clear so no overflow is ever lost.
  assign ovf_d    = (push & fifo_full & ~pop) ? 1'b1 : (accept ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= A_IDLE;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      timer_q   <= '0;
      rx_read_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      timer_q   <= timer_d;
      rx_read_q <= rx_read_d;
      done_q    <= accept;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  ps2_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (evt_in),
    .dout    (evt_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (evt_count)
  );

  assign rx_read  = rx_read_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: a byte-level reference model predicts each read result;
// a monitor pops predictions whenever done pulses.
module tb_ps2_key_sequencer;
  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic        clk;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_read;
  logic        clk_en;
  logic        start;
  logic        done;
  logic [31:0] result;
  logic [$clog2(DEPTH):0] evt_count;
  logic        overflow;

  ps2_key_sequencer #(
    .EVT_DEPTH   (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_read   (rx_read),
    .clk_en    (clk_en),
    .start     (start),
    .done      (done),
    .result    (result),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  rxq [$];
  logic [31:0] expq [$];
  logic [9:0]  mq [$];
  bit          m_ext, m_brk, m_ovf;
  int          tests, fails;
  logic [31:0] last_res;
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Receiver: presents the head byte, drops it on the pop strobe.
  always @(posedge clk) begin
    if (reset_n && rx_read && rxq.size() > 0) void'(rxq.pop_front());
  end
  always @(negedge clk) begin
    rx_valid = (rxq.size() > 0);
    rx_data  = rx_valid ? rxq[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (expq.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else begin
        mon_exp = expq.pop_front();
        check("result", result, mon_exp);
      end
    end
  end

  task automatic model_push(input logic [9:0] e);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (b != 8'hE1 && b != 8'h00 && b != 8'hFF) model_push({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_read(output logic [31:0] r);
    if (mq.size() == 0) r = 32'h0;
    else r = 32'h8000_0000 | (32'(m_ovf) << 30) | 32'(mq.pop_front());
    m_ovf = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    model_byte(b);
  endtask

  task automatic quiesce();
    int n = 0;
    while (rxq.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("quiesce_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic ci_read();
    logic [31:0] e;
    model_read(e);
    expq.push_back(e);
    last_res = e;
    start  = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    clk_en = 1'b0;
  endtask

  // Issue a read on the exact edge where the assembler pushes byte b.
  task automatic same_cycle_read(input logic [7:0] b);
    logic [31:0] e;
    bit ok = 1'b0;
    rxq.push_back(b);
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (rx_read) ok = 1'b1;
    end
    check("rx_read_seen", 32'(ok), 32'd1);
    if (ok) begin
      model_read(e);
      expq.push_back(e);
      last_res = e;
      model_byte(b);
      start  = 1'b1;
      clk_en = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      clk_en = 1'b0;
    end
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] b;
    b = 8'($urandom_range(1, 254));
    while (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) b = 8'($urandom_range(1, 254));
    return b;
  endfunction

  function automatic logic [7:0] rand_byte();
    int p;
    logic [7:0] d [3];
    d[0] = 8'hE1; d[1] = 8'h00; d[2] = 8'hFF;
    p = $urandom_range(0, 99);
    if (p < 15) return 8'hE0;
    if (p < 30) return 8'hF0;
    if (p < 36) return d[$urandom_range(0, 2)];
    return rand_code();
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_read"},  32'(rx_read), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_result"},   result, 32'd0);
    check({tag, "_evt_count"}, 32'(evt_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; last_res = 32'h0;
    model_clear();
    start = 1'b0; clk_en = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single code, latency and count
    send(8'h1C);
    quiesce();
    check("t1_count", 32'(evt_count), 32'd1);
    ci_read();
    check("t1_count_after", 32'(evt_count), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Prefix folding
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h75);
    quiesce();
    check("t2_count", 32'(evt_count), 32'd3);
    repeat (3) ci_read();

    // Prefix timeout, and a byte arriving just before timeout
    send(8'hE0);
    quiesce();
    repeat (TMO + 5) @(negedge clk);
    m_ext = 1'b0; m_brk = 1'b0;
    send(8'h1C);
    quiesce();
    ci_read();
    send(8'hE0);
    quiesce();
    repeat (TMO - 10) @(negedge clk);
    send(8'h75);
    quiesce();
    ci_read();

    // Overflow
    for (int i = 0; i < DEPTH + 1; i++) send(rand_code());
    quiesce();
    check("t4_count_full", 32'(evt_count), 32'(DEPTH));
    check("t4_overflow", 32'(overflow), 32'd1);
    ci_read();
    check("t4_overflow_cleared", 32'(overflow), 32'd0);
    repeat (DEPTH) ci_read();

    // clk_en low ignores start
    send(8'h1C);
    quiesce();
    start = 1'b1; clk_en = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("t5_no_pop", 32'(evt_count), 32'd1);
    check("t5_result_hold", result, last_res);
    ci_read();

    // Full queue: push and pop on the same edge
    for (int i = 0; i < DEPTH; i++) send(rand_code());
    quiesce();
    check("t5_full", 32'(evt_count), 32'(DEPTH));
    same_cycle_read(8'h2A);
    quiesce();
    check("t5_full_pp_ovf", 32'(overflow), 32'd0);
    check("t5_full_pp_count", 32'(evt_count), 32'(DEPTH));
    repeat (DEPTH + 1) ci_read();

    // Empty queue: push and pop on the same edge
    same_cycle_read(8'h3B);
    quiesce();
    check("t5_empty_pp_count", 32'(evt_count), 32'd1);
    ci_read();

    // Reset mid-prefix
    send(8'h1C); send(8'hE0);
    quiesce();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    rxq.delete();
    expq.delete();
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'h1C);
    quiesce();
    ci_read();

    // Randomized bursts and reads
    for (int it = 0; it < 30; it++) begin
      int nb, nr;
      nb = $urandom_range(0, 6);
      for (int k = 0; k < nb; k++) send(rand_byte());
      quiesce();
      repeat (TMO + 5) @(negedge clk);
      m_ext = 1'b0; m_brk = 1'b0;
      check("rnd_count", 32'(evt_count), 32'(mq.size()));
      check("rnd_overflow", 32'(overflow), 32'(m_ovf));
      nr = $urandom_range(0, 4);
      for (int k = 0; k < nr; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          start = 1'b1; clk_en = 1'b0;
          @(negedge clk);
          start = 1'b0;
        end
        ci_read();
      end
    end

    while (mq.size() > 0) ci_read();
    ci_read();
    repeat (3) @(negedge clk);
    check("all_reads_done", 32'(expq.size()), 32'd0);
    check("final_count", 32'(evt_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
